// File: rtl/os_ts_checker.sv
// os_ts_checker: per-lane TS1/TS2 ordered-set qualification for the LTSSM
// Polling and Configuration link-width substates. Each lane counts consecutive
// qualifying ordered sets and flags a match once COUNT_TARGET is reached.
// Optional feature: define OS_TS_CHECKER_RATE_CAPTURE_EN to capture lane 0's
// rate identifier and upconfigure bit when lane 0 first matches.
module os_ts_checker #(
   parameter int LANESNUMBER  = 4,
   parameter int DEVICETYPE   = 0,
   parameter int COUNT_TARGET = 8
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic [3:0]                 substate,
   input  logic [7:0]                 linkNumber,
   input  logic [128*LANESNUMBER-1:0] orderedset,
   input  logic [LANESNUMBER-1:0]     valid,
   output logic [LANESNUMBER-1:0]     lane_match,
   output logic                       all_match,
   output logic [LANESNUMBER-1:0]     countup,
   output logic [LANESNUMBER-1:0]     resetcounter,
   output logic [7:0]                 rateid,
   output logic                       upconfigure_capability
);

   localparam logic [7:0] PAD    = 8'hF7;
   localparam logic [7:0] TS1    = 8'h2A;
   localparam logic [7:0] TS2    = 8'h25;
   localparam logic [7:0] TARGET = 8'(COUNT_TARGET);

   typedef enum logic [2:0] {
      IDLE,
      POLL_ACT,
      POLL_CFG,
      CFG_LWS_DN,
      CFG_LWS_UP,
      CFG_LWA
   } state_t;

   state_t                        state;
   state_t                        next_state;
   logic                          state_chg;
   logic [LANESNUMBER-1:0][7:0]   cnt;
   logic [LANESNUMBER-1:0][7:0]   base_cnt;
   logic [LANESNUMBER-1:0][7:0]   cnt_next;
   logic [LANESNUMBER-1:0]        qual;
   logic [LANESNUMBER-1:0]        cu_next;
   logic [LANESNUMBER-1:0]        rc_next;
   logic [LANESNUMBER-1:0]        lm_next;

   // Only a handful of fields of each ordered set are inspected.
   logic unused_inputs;
   assign unused_inputs = ^orderedset;

   // Qualification of one lane's ordered set against the given state
   function automatic logic qualifies(input state_t st, input logic [127:0] os,
                                      input logic [7:0] lnk);
      logic [7:0] f_link;
      logic [7:0] f_lane;
      logic [7:0] f_id;
      logic       f_b42;
      logic       f_b43;
      logic       q;
      f_link = os[15:8];
      f_lane = os[23:16];
      f_id   = os[87:80];
      f_b42  = os[42];
      f_b43  = os[43];
      q      = 1'b0;
      case (st)
         POLL_ACT:   q = (f_link == PAD) && (f_lane == PAD) &&
                         (((f_id == TS1) && !f_b43) || ((f_id == TS1) && f_b42) ||
                          (f_id == TS2));
         POLL_CFG:   q = (f_link == PAD) && (f_lane == PAD) && (f_id == TS2);
         CFG_LWS_DN: q = (f_link == lnk) && (f_lane == PAD) && (f_id == TS1) && !f_b43;
         CFG_LWS_UP: q = (f_link != PAD) && (f_lane == PAD) && (f_id == TS1) && !f_b43;
         CFG_LWA:    q = (f_link == lnk) && (f_lane != PAD) && (f_id == TS1);
         default:    q = 1'b0;
      endcase
      return q;
   endfunction

   // Next state follows the LTSSM substate directly
   always_comb begin
      next_state = IDLE;
      case (substate)
         4'd2:    next_state = POLL_ACT;
         4'd3:    next_state = POLL_CFG;
         4'd4:    next_state = (DEVICETYPE == 1) ? CFG_LWS_UP : CFG_LWS_DN;
         4'd5:    next_state = CFG_LWA;
         default: next_state = IDLE;
      endcase
   end

   // Per-lane counter update: a state change restarts every lane from zero,
   // and the set presented in that same cycle is judged against the new state
   always_comb begin
      state_chg = (next_state != state);
      for (int i = 0; i < LANESNUMBER; i++) begin
         qual[i]     = qualifies(next_state, orderedset[128*i +: 128], linkNumber);
         base_cnt[i] = state_chg ? 8'd0 : cnt[i];
         cnt_next[i] = base_cnt[i];
         cu_next[i]  = 1'b0;
         rc_next[i]  = 1'b0;
         if (next_state == IDLE) begin
            cnt_next[i] = 8'd0;
         end else if (valid[i]) begin
            if (qual[i]) begin
               if (base_cnt[i] != TARGET) begin
                  cnt_next[i] = base_cnt[i] + 8'd1;
                  cu_next[i]  = 1'b1;
               end
            end else begin
               cnt_next[i] = 8'd0;
               rc_next[i]  = (base_cnt[i] != 8'd0);
            end
         end
         lm_next[i] = (cnt_next[i] == TARGET);
      end
   end

   // State, counters and registered flags/pulses
   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= IDLE;
         cnt          <= '0;
         lane_match   <= '0;
         all_match    <= 1'b0;
         countup      <= '0;
         resetcounter <= '0;
      end else begin
         state        <= next_state;
         cnt          <= cnt_next;
         lane_match   <= lm_next;
         all_match    <= &lm_next;
         countup      <= cu_next;
         resetcounter <= rc_next;
      end
   end

`ifdef OS_TS_CHECKER_RATE_CAPTURE_EN
   // Capture lane 0's rate fields from the set that makes lane 0 match
   always_ff @(posedge clk) begin
      if (reset) begin
         rateid                 <= 8'h00;
         upconfigure_capability <= 1'b0;
      end else if (lm_next[0] && !lane_match[0]) begin
         rateid                 <= orderedset[39:32];
         upconfigure_capability <= orderedset[38];
      end
   end
`else
   assign rateid                 = 8'h00;
   assign upconfigure_capability = 1'b0;
`endif

endmodule

// File: tb/tb_os_ts_checker.sv
// Self-checking bench for os_ts_checker: directed scenarios plus randomized
// ordered sets, all compared against a behavioural per-lane count model.
module tb_os_ts_checker;

   localparam int LN = 4;
   localparam int DT = 0;
   localparam int CT = 8;
   localparam logic [7:0] PAD = 8'hF7;
   localparam logic [7:0] TS1 = 8'h2A;
   localparam logic [7:0] TS2 = 8'h25;

   logic              clk = 1'b0;
   logic              reset;
   logic [3:0]        substate;
   logic [7:0]        linkNumber;
   logic [128*LN-1:0] orderedset;
   logic [LN-1:0]     valid;
   logic [LN-1:0]     lane_match;
   logic              all_match;
   logic [LN-1:0]     countup;
   logic [LN-1:0]     resetcounter;
   logic [7:0]        rateid;
   logic              upconfigure_capability;

   int n_assert = 0;
   int n_fail   = 0;

   // reference model state
   int            mcnt[LN];
   logic [LN-1:0] mlm;
   logic          mall;
   logic [LN-1:0] ecu;
   logic [LN-1:0] erc;
   logic [7:0]    erate;
   logic          eup;
   int            prev_mode;
   int            tally[LN];

   always #5 clk = ~clk;

   os_ts_checker #(.LANESNUMBER(LN), .DEVICETYPE(DT), .COUNT_TARGET(CT)) dut (
      .clk(clk),
      .reset(reset),
      .substate(substate),
      .linkNumber(linkNumber),
      .orderedset(orderedset),
      .valid(valid),
      .lane_match(lane_match),
      .all_match(all_match),
      .countup(countup),
      .resetcounter(resetcounter),
      .rateid(rateid),
      .upconfigure_capability(upconfigure_capability)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [127:0] mk(input logic [7:0] id, input logic [7:0] link,
                                       input logic [7:0] lane, input logic [7:0] rate,
                                       input logic b42, input logic b43);
      logic [127:0] os;
      os = {$urandom, $urandom, $urandom, $urandom};
      os[15:8]  = link;
      os[23:16] = lane;
      os[39:32] = rate;
      os[42]    = b42;
      os[43]    = b43;
      os[87:80] = id;
      return os;
   endfunction

   function automatic logic rb();
      return 1'($urandom_range(0, 1));
   endfunction

   function automatic logic [7:0] rbyte();
      return 8'($urandom_range(0, 255));
   endfunction

   function automatic logic [7:0] non_pad();
      return 8'($urandom_range(0, 246));
   endfunction

   // A set meant to qualify in the state selected by the given substate
   function automatic logic [127:0] good_os(input logic [3:0] s);
      case (s)
         4'd2:    return mk(TS1, PAD, PAD, rbyte(), rb(), 1'b0);
         4'd3:    return mk(TS2, PAD, PAD, rbyte(), rb(), rb());
         4'd4:    return mk(TS1, linkNumber, PAD, rbyte(), rb(), 1'b0);
         4'd5:    return mk(TS1, linkNumber, non_pad(), rbyte(), rb(), rb());
         default: return mk(TS1, PAD, PAD, rbyte(), rb(), rb());
      endcase
   endfunction

   function automatic logic [127:0] rand_os();
      case ($urandom_range(0, 7))
         0: return mk(TS1, PAD, PAD, rbyte(), rb(), 1'b0);
         1: return mk(TS1, PAD, PAD, rbyte(), 1'b1, 1'b1);
         2: return mk(TS1, PAD, PAD, rbyte(), 1'b0, 1'b1);
         3: return mk(TS2, PAD, PAD, rbyte(), rb(), rb());
         4: return mk(TS1, linkNumber, PAD, rbyte(), rb(), rb());
         5: return mk(TS1, linkNumber, non_pad(), rbyte(), rb(), rb());
         6: return mk(TS1, rbyte(), PAD, rbyte(), rb(), rb());
         default: return mk(rbyte(), rbyte(), rbyte(), rbyte(), rb(), rb());
      endcase
   endfunction

   function automatic int mode_of(input logic [3:0] s);
      case (s)
         4'd2:    return 1;
         4'd3:    return 2;
         4'd4:    return (DT == 1) ? 4 : 3;
         4'd5:    return 5;
         default: return 0;
      endcase
   endfunction

   // 1 poll-active, 2 poll-config, 3 lws downstream, 4 lws upstream, 5 lwa
   function automatic bit qual(input int mode, input logic [127:0] os, input logic [7:0] lnk);
      logic [7:0] link;
      logic [7:0] lane;
      logic [7:0] id;
      link = os[15:8];
      lane = os[23:16];
      id   = os[87:80];
      case (mode)
         1: return link == PAD && lane == PAD &&
                   (id == TS2 || (id == TS1 && (!os[43] || os[42])));
         2: return link == PAD && lane == PAD && id == TS2;
         3: return link == lnk && lane == PAD && id == TS1 && !os[43];
         4: return link != PAD && lane == PAD && id == TS1 && !os[43];
         5: return link == lnk && lane != PAD && id == TS1;
         default: return 0;
      endcase
   endfunction

   task automatic model_step();
      int   mode;
      int   c;
      logic lm0_old;
      logic [127:0] os;
      ecu = '0;
      erc = '0;
      if (reset) begin
         for (int i = 0; i < LN; i++) mcnt[i] = 0;
         mlm       = '0;
         mall      = 1'b0;
         erate     = 8'h00;
         eup       = 1'b0;
         prev_mode = 0;
      end else begin
         mode      = mode_of(substate);
         lm0_old   = mlm[0];
         for (int i = 0; i < LN; i++) begin
            os = orderedset[128*i +: 128];
            c  = (mode != prev_mode) ? 0 : mcnt[i];
            if (mode == 0) c = 0;
            else if (valid[i]) begin
               if (qual(mode, os, linkNumber)) begin
                  if (c < CT) begin
                     c++;
                     ecu[i] = 1'b1;
                  end
               end else begin
                  if (c != 0) erc[i] = 1'b1;
                  c = 0;
               end
            end
            mcnt[i] = c;
            mlm[i]  = (c == CT);
         end
         prev_mode = mode;
         mall      = &mlm;
`ifdef OS_TS_CHECKER_RATE_CAPTURE_EN
         if (mlm[0] && !lm0_old) begin
            erate = orderedset[39:32];
            eup   = orderedset[38];
         end
`endif
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      #1;
      chk("lane_match", 32'(lane_match), 32'(mlm));
      chk("all_match", 32'(all_match), 32'(mall));
      chk("countup", 32'(countup), 32'(ecu));
      chk("resetcounter", 32'(resetcounter), 32'(erc));
      chk("rateid", 32'(rateid), 32'(erate));
      chk("upcfg", 32'(upconfigure_capability), 32'(eup));
   endtask

   initial begin
      reset      = 1'b1;
      substate   = 4'd0;
      linkNumber = 8'h05;
      orderedset = '0;
      valid      = '0;
      for (int i = 0; i < LN; i++) mcnt[i] = 0;
      mlm = '0; mall = 1'b0; ecu = '0; erc = '0; erate = 8'h00; eup = 1'b0; prev_mode = 0;

      // reset state
      tick();
      tick();
      chk("reset_lane_match", 32'(lane_match), 32'h0);
      chk("reset_rateid", 32'(rateid), 32'h0);
      reset = 1'b0;

      // polling active: 8 consecutive TS1 on all lanes
      substate = 4'd2;
      valid    = '1;
      for (int i = 0; i < LN; i++) tally[i] = 0;
      for (int k = 0; k < 8; k++) begin
         for (int i = 0; i < LN; i++) orderedset[128*i +: 128] = mk(TS1, PAD, PAD, rbyte(), rb(), 1'b0);
         tick();
         for (int i = 0; i < LN; i++) tally[i] += int'(countup[i]);
         if (k == 6) chk("poll_before_target", 32'(lane_match), 32'h0);
      end
      chk("poll_lane_match", 32'(lane_match), 32'hF);
      chk("poll_all_match", 32'(all_match), 32'h1);
      for (int i = 0; i < LN; i++) chk("poll_countup_tally", 32'(tally[i]), 32'd8);

      // saturation: extra qualifying sets produce no pulse
      for (int k = 0; k < 2; k++) begin
         for (int i = 0; i < LN; i++) orderedset[128*i +: 128] = mk(TS2, PAD, PAD, rbyte(), rb(), rb());
         tick();
         chk("sat_countup", 32'(countup), 32'h0);
         chk("sat_lane_match", 32'(lane_match), 32'hF);
      end

      // randomized polling-active traffic
      for (int k = 0; k < 60; k++) begin
         valid = 4'($urandom_range(0, 15));
         for (int i = 0; i < LN; i++)
            orderedset[128*i +: 128] = ($urandom_range(0, 1) == 1) ? good_os(substate) : rand_os();
         tick();
      end

      // substate change mid-count: count 6, then 2 -> 3 with TS2 present
      valid = '1;
      for (int i = 0; i < LN; i++) orderedset[128*i +: 128] = mk(8'h00, PAD, PAD, rbyte(), rb(), rb());
      tick();
      for (int k = 0; k < 6; k++) begin
         for (int i = 0; i < LN; i++) orderedset[128*i +: 128] = mk(TS1, PAD, PAD, rbyte(), rb(), 1'b0);
         tick();
      end
      substate = 4'd3;
      for (int i = 0; i < LN; i++) orderedset[128*i +: 128] = mk(TS2, PAD, PAD, rbyte(), rb(), rb());
      tick();
      chk("chg_resetcounter", 32'(resetcounter), 32'h0);
      chk("chg_countup", 32'(countup), 32'hF);
      for (int k = 0; k < 7; k++) begin
         for (int i = 0; i < LN; i++) orderedset[128*i +: 128] = mk(TS2, PAD, PAD, rbyte(), rb(), rb());
         tick();
         if (k == 5) chk("chg_before_target", 32'(lane_match), 32'h0);
      end
      chk("chg_lane_match", 32'(lane_match), 32'hF);

      // mismatch on lane 2: 5 TS2, 1 TS1, 8 TS2
      substate = 4'd9;
      valid    = '0;
      tick();
      substate = 4'd3;
      valid    = 4'b0100;
      tally[2] = 0;
      for (int k = 0; k < 14; k++) begin
         for (int i = 0; i < LN; i++) orderedset[128*i +: 128] = rand_os();
         orderedset[256 +: 128] = (k == 5) ? mk(TS1, PAD, PAD, rbyte(), rb(), 1'b0)
                                           : mk(TS2, PAD, PAD, rbyte(), rb(), rb());
         tick();
         tally[2] += int'(resetcounter[2]);
         if (k == 12) chk("mis_before_target", 32'(lane_match[2]), 32'h0);
      end
      chk("mis_lane_match2", 32'(lane_match[2]), 32'h1);
      chk("mis_rc_tally", 32'(tally[2]), 32'd1);

      // downstream link width start: lanes 2,3 carry the wrong link number
      substate   = 4'd4;
      linkNumber = 8'h05;
      valid      = '1;
      for (int k = 0; k < 8; k++) begin
         for (int i = 0; i < LN; i++)
            orderedset[128*i +: 128] = mk(TS1, (i < 2) ? 8'h05 : 8'h06, PAD, rbyte(), rb(), 1'b0);
         tick();
      end
      chk("lws_lane_match", 32'(lane_match), 32'h3);
      chk("lws_all_match", 32'(all_match), 32'h0);

      // randomized traffic with occasional substate and link number changes
      for (int k = 0; k < 150; k++) begin
         if ($urandom_range(0, 15) == 0) substate = 4'($urandom_range(0, 9));
         if ($urandom_range(0, 31) == 0) linkNumber = ($urandom_range(0, 1) == 1) ? 8'h05 : rbyte();
         valid = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'hF;
         for (int i = 0; i < LN; i++)
            orderedset[128*i +: 128] = ($urandom_range(0, 3) != 0) ? good_os(substate) : rand_os();
         tick();
      end

      // reset mid-count with valid held high
      substate   = 4'd0;
      linkNumber = 8'h05;
      tick();
      substate = 4'd2;
      valid    = '1;
      for (int k = 0; k < 4; k++) begin
         for (int i = 0; i < LN; i++) orderedset[128*i +: 128] = mk(TS1, PAD, PAD, rbyte(), rb(), 1'b0);
         tick();
      end
      reset = 1'b1;
      for (int i = 0; i < LN; i++) orderedset[128*i +: 128] = mk(TS1, PAD, PAD, rbyte(), rb(), 1'b0);
      tick();
      chk("rst_lane_match", 32'(lane_match), 32'h0);
      chk("rst_countup", 32'(countup), 32'h0);
      chk("rst_all_match", 32'(all_match), 32'h0);
      chk("rst_rateid", 32'(rateid), 32'h0);
      reset = 1'b0;
      tick();
      chk("rst_restart_countup", 32'(countup), 32'hF);
      for (int k = 0; k < 7; k++) begin
         for (int i = 0; i < LN; i++) orderedset[128*i +: 128] = mk(TS1, PAD, PAD, rbyte(), rb(), 1'b0);
         tick();
         if (k == 5) chk("rst_before_target", 32'(lane_match), 32'h0);
      end
      chk("rst_lane_match_after", 32'(lane_match), 32'hF);

      // rate capture: lane 0 matches with rate 8'h1E, then with 8'h5A
      for (int pass = 0; pass < 2; pass++) begin
         substate = 4'd0;
         tick();
         substate = 4'd2;
         for (int k = 0; k < 9; k++) begin
            for (int i = 0; i < LN; i++) orderedset[128*i +: 128] = mk(TS1, PAD, PAD, rbyte(), rb(), 1'b0);
            orderedset[39:32] = (k == 8) ? 8'h33 : ((pass == 0) ? 8'h1E : 8'h5A);
            tick();
         end
`ifdef OS_TS_CHECKER_RATE_CAPTURE_EN
         chk("cap_rateid", 32'(rateid), (pass == 0) ? 32'h1E : 32'h5A);
         chk("cap_upcfg", 32'(upconfigure_capability), (pass == 0) ? 32'h0 : 32'h1);
`else
         chk("nocap_rateid", 32'(rateid), 32'h00);
         chk("nocap_upcfg", 32'(upconfigure_capability), 32'h0);
`endif
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
